cms_stream_unpacker: RTL and testbench



---
 rtl/cms_pkg.sv | 20 ++
 rtl/cms_stream_unpacker_if.sv | 26 ++
 rtl/cms_tlast_checker.sv | 41 ++++
 rtl/cms_stream_unpacker.sv | 88 ++++++++
 tb/tb_cms_stream_unpacker.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cms_pkg.sv
// Shared widths, counter size and FSM state type for the CMS stream unpacker.
package cms_pkg;

    localparam int unsigned DEF_IN_WIDTH  = 512;
    localparam int unsigned DEF_OUT_WIDTH = 64;
    localparam int unsigned DEF_RATIO     = DEF_IN_WIDTH / DEF_OUT_WIDTH;
    localparam int unsigned CNT_WIDTH     = 32;

    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int unsigned DEF_IDX_WIDTH = idx_width(DEF_RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/cms_stream_unpacker_if.sv
// Wide S_AXIS input plus narrow output stream of the unpacker.
interface cms_stream_unpacker_if
    import cms_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
);
    logic                 S_AXIS_tvalid;
    logic                 S_AXIS_tready;
    logic [IN_WIDTH-1:0]  S_AXIS_tdata;
    logic                 S_AXIS_tlast;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport slave (
        input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
        output S_AXIS_tready, out_valid, out_data, out_last
    );

    modport master (
        output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
        input  S_AXIS_tready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cms_tlast_checker.sv
// Checks tlast spacing against the programmed interval; tlast_err is sticky until err_clr.
module cms_tlast_checker
    import cms_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_beat,
    input  logic                 i_tlast,
    input  logic                 i_err_clr,
    input  logic [CNT_WIDTH-1:0] i_interval,
    output logic                 o_tlast_err
);
    logic [CNT_WIDTH-1:0] r_sc;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] w_sc_inc;
    logic                 w_at_interval;

    assign w_sc_inc      = r_sc + CNT_WIDTH'(1);
    assign w_at_interval = (w_sc_inc == i_interval);
    assign o_tlast_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc  <= '0;
            r_err <= 1'b0;
        end else if (i_err_clr) begin
            // Clear wins over a same-cycle beat; that beat goes unchecked.
            r_sc  <= '0;
            r_err <= 1'b0;
        end else if (i_interval == '0) begin
            r_sc <= '0;
        end else if (i_beat) begin
            if (i_tlast || w_at_interval) begin
                r_sc <= '0;
                if (i_tlast != w_at_interval) r_err <= 1'b1;
            end else begin
                r_sc <= w_sc_inc;
            end
        end
    end
endmodule

// File: rtl/cms_stream_unpacker.sv
// Serialises 512-bit S_AXIS beats into 64-bit words, LSB word first, and keeps beat statistics.
// Define CMS_UNPACK_TLAST_CHECK_EN to build in the tlast spacing checker.
module cms_stream_unpacker
    import cms_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    cms_stream_unpacker_if.slave  s_bus,
    input  logic [CNT_WIDTH-1:0]  tlast_interval,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  tlast_err,
    input  logic                  err_clr
);
    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = idx_width(RATIO);

    state_e               r_state;
    logic [IN_WIDTH-1:0]  r_hold;
    logic                 r_hold_last;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_WIDTH-1:0] r_beat_count;
    logic [CNT_WIDTH-1:0] r_xfer_count;

    logic                 w_valid;
    logic                 w_last_idx;
    logic                 w_tready;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic [OUT_WIDTH-1:0] w_word;

    assign w_valid    = (r_state == DRAIN);
    assign w_last_idx = (r_idx == IDX_W'(RATIO - 1));
    assign w_out_hs   = w_valid & s_bus.out_ready;
    // Accept a new beat as the final word leaves, so back-to-back beats need no bubble.
    assign w_tready   = !rst & ((r_state == EMPTY) | (w_out_hs & w_last_idx));
    assign w_in_hs    = s_bus.S_AXIS_tvalid & w_tready;
    assign w_word     = r_hold[32'(r_idx) * OUT_WIDTH +: OUT_WIDTH];

    assign s_bus.S_AXIS_tready = w_tready;
    assign s_bus.out_valid     = w_valid;
    assign s_bus.out_data      = w_valid ? w_word : '0;
    assign s_bus.out_last      = w_valid & r_hold_last & w_last_idx;
    assign beat_count          = r_beat_count;
    assign xfer_count          = r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_hold       <= '0;
            r_hold_last  <= 1'b0;
            r_idx        <= '0;
            r_beat_count <= '0;
            r_xfer_count <= '0;
        end else begin
            if (w_in_hs) begin
                r_state      <= DRAIN;
                r_hold       <= s_bus.S_AXIS_tdata;
                r_hold_last  <= s_bus.S_AXIS_tlast;
                r_idx        <= '0;
                r_beat_count <= r_beat_count + CNT_WIDTH'(1);
                if (s_bus.S_AXIS_tlast) r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
            end else if (w_out_hs) begin
                if (w_last_idx) r_state <= EMPTY;
                else            r_idx   <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef CMS_UNPACK_TLAST_CHECK_EN
    cms_tlast_checker u_tlast_checker (
        .clk         (clk),
        .rst         (rst),
        .i_beat      (w_in_hs),
        .i_tlast     (s_bus.S_AXIS_tlast),
        .i_err_clr   (err_clr),
        .i_interval  (tlast_interval),
        .o_tlast_err (tlast_err)
    );
`else
    logic w_unused_chk;
    assign w_unused_chk = ^{err_clr, tlast_interval};
    assign tlast_err    = 1'b0;
`endif
endmodule

// File: tb/tb_cms_stream_unpacker.sv
// Randomised bench for cms_stream_unpacker checked against a word-queue reference model.
module tb_cms_stream_unpacker;
    localparam int unsigned IW = 512;
    localparam int unsigned OW = 64;
    localparam int unsigned R  = IW / OW;
`ifdef CMS_UNPACK_TLAST_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [OW-1:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tlast_interval = '0;
    logic [31:0] beat_count;
    logic [31:0] xfer_count;
    logic        tlast_err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    cms_stream_unpacker_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    cms_stream_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_bus          (bus),
        .tlast_interval (tlast_interval),
        .beat_count     (beat_count),
        .xfer_count     (xfer_count),
        .tlast_err      (tlast_err),
        .err_clr        (err_clr)
    );

    // Reference model: pending output words plus plain statistics.
    word_t       q[$];
    int unsigned m_beats = 0;
    int unsigned m_xfers = 0;
    int unsigned m_run   = 0;
    logic        m_err   = 1'b0;

    int errors = 0;
    int checks = 0;

    // Phase knobs (percentages).
    int p_valid, p_ready, p_last, p_clr, p_rst, every_n, gen_n;
    bit pattern;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic          m_tready;
        bit            in_hs;
        logic [IW-1:0] d;
        if (!bus.S_AXIS_tvalid && ($urandom_range(99) < p_valid)) begin
            for (int k = 0; k < int'(IW / 32); k++) d[k*32 +: 32] = $urandom();
            if (pattern) for (int k = 0; k < int'(R); k++) d[k*OW +: OW] = OW'(k + 1);
            gen_n++;
            bus.S_AXIS_tdata  = d;
            bus.S_AXIS_tlast  = (every_n != 0) ? ((gen_n % every_n) == 0)
                                               : ($urandom_range(99) < p_last);
            bus.S_AXIS_tvalid = 1'b1;
        end
        bus.out_ready = ($urandom_range(99) < p_ready);
        err_clr       = ($urandom_range(99) < p_clr);
        rst           = ($urandom_range(99) < p_rst);
        #1;
        m_tready = !rst && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
        check_eq("tready", bus.S_AXIS_tready, m_tready);
        check_eq("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_data", bus.out_data, q[0].data);
            check_eq("out_last", bus.out_last, q[0].last);
        end
        check_eq("beat_count", beat_count, m_beats);
        check_eq("xfer_count", xfer_count, m_xfers);
        check_eq("tlast_err", tlast_err, CHK_EN ? m_err : 1'b0);
        @(posedge clk);
        in_hs = 1'b0;
        if (rst) begin
            q.delete();
            m_beats = 0;
            m_xfers = 0;
            m_run   = 0;
            m_err   = 1'b0;
        end else begin
            in_hs = bus.S_AXIS_tvalid && m_tready;
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (in_hs) begin
                for (int k = 0; k < int'(R); k++)
                    q.push_back({bus.S_AXIS_tlast && (k == int'(R) - 1),
                                 bus.S_AXIS_tdata[k*OW +: OW]});
                m_beats++;
                if (bus.S_AXIS_tlast) m_xfers++;
            end
            // Beats counted within the current transfer must land tlast exactly on the interval.
            if (err_clr) begin
                m_err = 1'b0;
                m_run = 0;
            end else if (tlast_interval == 0) begin
                m_run = 0;
            end else if (in_hs) begin
                m_run++;
                if (bus.S_AXIS_tlast) begin
                    if (m_run != tlast_interval) m_err = 1'b1;
                    m_run = 0;
                end else if (m_run == tlast_interval) begin
                    m_err = 1'b1;
                    m_run = 0;
                end
            end
        end
        @(negedge clk);
        if (in_hs) bus.S_AXIS_tvalid = 1'b0;
    endtask

    // Let any pending beat be accepted, then pulse err_clr so a new phase starts aligned.
    task automatic flush();
        int n;
        p_valid = 0; p_ready = 100; p_clr = 0; p_rst = 0;
        n = 0;
        while (bus.S_AXIS_tvalid && n < 100) begin
            cycle();
            n++;
        end
        check_eq("flush_timeout", bus.S_AXIS_tvalid, 1'b0);
        p_clr = 100;
        cycle();
        p_clr = 0;
        gen_n = 0;
    endtask

    task automatic run_phase(input int v, input int rdy, input int lst, input int en,
                             input int clr, input int rs, input int unsigned intv,
                             input bit pat, input int ncyc);
        flush();
        tlast_interval = intv;
        p_valid = v; p_ready = rdy; p_last = lst; every_n = en;
        p_clr = clr; p_rst = rs; pattern = pat;
        for (int i = 0; i < ncyc; i++) cycle();
    endtask

    initial begin
        bus.S_AXIS_tvalid = 1'b0;
        bus.S_AXIS_tdata  = '0;
        bus.S_AXIS_tlast  = 1'b0;
        bus.out_ready     = 1'b0;
        gen_n = 0; pattern = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tready", bus.S_AXIS_tready, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_tready", bus.S_AXIS_tready, 1'b1);
        check_eq("post_rst_valid", bus.out_valid, 1'b0);
        check_eq("post_rst_data", bus.out_data, 64'd0);
        check_eq("post_rst_last", bus.out_last, 1'b0);
        check_eq("post_rst_beats", beat_count, 64'd0);
        check_eq("post_rst_err", tlast_err, 1'b0);
        @(negedge clk);

        run_phase(100, 100, 0, 1, 0, 0, 1, 1'b1, 60);
        run_phase(100, 50, 30, 0, 0, 0, 0, 1'b0, 1500);
        run_phase(40, 80, 0, 4, 0, 0, 4, 1'b0, 1500);
        check_eq("aligned_err", tlast_err, 1'b0);
        run_phase(80, 70, 30, 0, 3, 0, 4, 1'b0, 1500);
        run_phase(90, 90, 10, 0, 2, 0, 2, 1'b0, 1500);
        run_phase(70, 70, 30, 0, 1, 2, 3, 1'b0, 1500);
        run_phase(100, 100, 40, 0, 0, 0, 0, 1'b0, 500);
        run_phase(100, 30, 0, 5, 0, 0, 5, 1'b0, 800);
        check_eq("aligned_err2", tlast_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
